// File: rtl/gmii_burst_gen_if.sv
// Control and GMII transmit bundle for gmii_burst_gen.
// master: generator side; slave: controller / GMII consumer side.
interface gmii_burst_gen_if #(
    parameter int unsigned LEN_W = 12,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_frames;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       ipg_len;
    logic [7:0]       seed;
    logic             err_en;
    logic [LEN_W-1:0] err_idx;
    logic [7:0]       TXD;
    logic             TX_EN;
    logic             TX_ER;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        input  start, num_frames, frame_len, ipg_len, seed, err_en, err_idx,
        output TXD, TX_EN, TX_ER, busy, done, frame_cnt
    );

    modport slave (
        output start, num_frames, frame_len, ipg_len, seed, err_en, err_idx,
        input  TXD, TX_EN, TX_ER, busy, done, frame_cnt
    );
endinterface

// File: rtl/gmii_burst_gen.sv
// GMII burst source: N frames of preamble, SFD, counting payload, then IPG.
// Optional TX_ER injection on one payload index when GMII_GEN_ERR_INJECT_EN is defined.
module gmii_burst_gen #(
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned IPG_MIN = 12
) (
    input logic              GTX_CLK,
    input logic              RESET,
    gmii_burst_gen_if.master bus
);

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_IPG,
        ST_FIN
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] idx_q;
    logic [7:0]       gap_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       ipg_q;
    logic [CNT_W-1:0] nf_q;
    logic [7:0]       fseed_q;
    logic [7:0]       txd_q;
    logic             tx_en_q;
    logic             tx_er_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic [LEN_W-1:0] len_d;
    logic [7:0]       ipg_d;
    logic [LEN_W-1:0] idx_inc_c;
    logic             pre_last_c;
    logic             data_last_c;
    logic             gap_last_c;
    logic             er_first_c;
    logic             er_next_c;

    // Clamped burst configuration and per-state terminal counts.
    assign len_d       = (bus.frame_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : bus.frame_len;
    assign ipg_d       = (bus.ipg_len < 8'(IPG_MIN)) ? 8'(IPG_MIN) : bus.ipg_len;
    assign idx_inc_c   = idx_q + LEN_W'(1);
    assign pre_last_c  = (idx_q == LEN_W'(PRE_LEN - 1));
    assign data_last_c = (idx_q == (len_q - LEN_W'(1)));
    assign gap_last_c  = (gap_q == (ipg_q - 8'd1));

`ifdef GMII_GEN_ERR_INJECT_EN
    logic             err_en_q;
    logic [LEN_W-1:0] err_idx_q;

    // Indices only reach L-1, so err_idx >= L never matches.
    assign er_first_c = err_en_q && (err_idx_q == '0);
    assign er_next_c  = err_en_q && (err_idx_q == idx_inc_c);

    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            err_en_q  <= 1'b0;
            err_idx_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            err_en_q  <= bus.err_en;
            err_idx_q <= bus.err_idx;
        end
    end
`else
    logic unused_err;

    assign er_first_c = 1'b0;
    assign er_next_c  = 1'b0;
    assign unused_err = ^{bus.err_en, bus.err_idx};
`endif

    // Outputs are loaded together with the state they belong to.
    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            len_q       <= LEN_W'(MIN_LEN);
            ipg_q       <= 8'(IPG_MIN);
            nf_q        <= '0;
            fseed_q     <= '0;
            txd_q       <= '0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        nf_q        <= bus.num_frames;
                        len_q       <= len_d;
                        ipg_q       <= ipg_d;
                        fseed_q     <= bus.seed;
                        frame_cnt_q <= '0;
                        if (bus.num_frames != '0) begin
                            state_q <= ST_PRE;
                            idx_q   <= '0;
                            tx_en_q <= 1'b1;
                            txd_q   <= PRE_BYTE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_PRE: begin
                    if (pre_last_c) begin
                        state_q <= ST_SFD;
                        txd_q   <= SFD_BYTE;
                    end else begin
                        idx_q <= idx_inc_c;
                    end
                end
                ST_SFD: begin
                    state_q <= ST_DATA;
                    idx_q   <= '0;
                    txd_q   <= fseed_q;
                    tx_er_q <= er_first_c;
                end
                ST_DATA: begin
                    if (data_last_c) begin
                        state_q     <= ST_IPG;
                        gap_q       <= '0;
                        tx_en_q     <= 1'b0;
                        tx_er_q     <= 1'b0;
                        txd_q       <= '0;
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        fseed_q     <= fseed_q + 8'd1;
                    end else begin
                        idx_q   <= idx_inc_c;
                        txd_q   <= fseed_q + 8'(idx_inc_c);
                        tx_er_q <= er_next_c;
                    end
                end
                ST_IPG: begin
                    if (gap_last_c) begin
                        if (frame_cnt_q == nf_q) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PRE;
                            idx_q   <= '0;
                            tx_en_q <= 1'b1;
                            txd_q   <= PRE_BYTE;
                        end
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    txd_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TXD       = txd_q;
    assign bus.TX_EN     = tx_en_q;
    assign bus.TX_ER     = tx_er_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule
